mem_stage: RTL and testbench

Pipeline stage 4 (MEM) of the 5-level MIPS CPU, fed directly by the EX->ME register (ans_me, b_me, rw_me, wreg_me, m2reg_me, wmem_me). It runs word loads and stores on an external data-memory bus through a req/ack handshake. While an access is in flight it stalls the upstream stages. It also holds the ME->WB pipeline register, which it writes with the stage result or a bubble.

---
 rtl/mem_stage_if.sv | 31 +++
 rtl/mem_stage.sv | 172 +++++++++++++++++
 tb/tb_mem_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage and an external data memory.
// Request side is registered in the stage; ack is a one-cycle strobe and
// rdata is only meaningful in the ack cycle.
interface mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   // The pipeline stage issues requests and consumes completions.
   modport master (
      output dmem_req,
      output dmem_we,
      output dmem_addr,
      output dmem_wdata,
      input  dmem_ack,
      input  dmem_rdata
   );

   // The memory accepts requests and answers with ack/rdata.
   modport slave (
      input  dmem_req,
      input  dmem_we,
      input  dmem_addr,
      input  dmem_wdata,
      output dmem_ack,
      output dmem_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline. Issues word loads/stores on a
// req/ack bus, stalls upstream while an access is outstanding, aborts an
// access that is not acknowledged within TIMEOUT cycles, and owns the ME->WB
// pipeline register (stage result or bubble).
module mem_stage #(
   parameter int unsigned TIMEOUT = 16   // legal range 2..255
) (
   input  logic               clock,
   input  logic               reset_0,
   // EX->ME register
   input  logic [31:0]        ans_me,
   input  logic [31:0]        b_me,
   input  logic [4:0]         rw_me,
   input  logic               wreg_me,
   input  logic               m2reg_me,
   input  logic               wmem_me,
   // upstream hold
   output logic               stall_me,
   // data-memory bus
   mem_stage_if.master        bus,
   // ME->WB register
   output logic [31:0]        ans_wb,
   output logic [31:0]        mo_wb,
   output logic [4:0]         rw_wb,
   output logic               wreg_wb,
   output logic               m2reg_wb,
   // error pulses
   output logic               align_err,
   output logic               bus_err
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   typedef struct packed {
      logic [31:0] ans;
      logic [31:0] mo;
      logic [4:0]  rw;
      logic        wreg;
      logic        m2reg;
   } wb_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q,  state_nxt;
   logic [7:0]  cnt_q,    cnt_nxt;
   logic        req_q,    req_nxt;
   logic        we_q,     we_nxt;
   logic [31:0] addr_q,   addr_nxt;
   logic [31:0] wdata_q,  wdata_nxt;
   wb_t         wb_q,     wb_nxt;
   logic        align_q,  align_nxt;
   logic        berr_q,   berr_nxt;

   logic memop;
   logic misaligned;
   logic last_cycle;

   assign memop      = m2reg_me | wmem_me;
   assign misaligned = memop & (ans_me[1:0] != 2'b00);
   // The access leaves BUSY this cycle, either completed or aborted.
   assign last_cycle = (state_q == BUSY) & (bus.dmem_ack | (cnt_q == CNT_LAST));

   // Upstream holds while an aligned access has not yet reached its final cycle.
   assign stall_me = memop & ~misaligned & ~last_cycle;

   // Next-state, bus-request and WB-register values.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // leaves a value unassigned and no latch is inferred.
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      req_nxt   = req_q;
      we_nxt    = we_q;
      addr_nxt  = addr_q;
      wdata_nxt = wdata_q;
      align_nxt = 1'b0;
      berr_nxt  = 1'b0;
      // bubble: no register write; memory data keeps its old value
      wb_nxt       = '0;
      wb_nxt.mo    = wb_q.mo;

      unique case (state_q)
         IDLE: begin
            if (memop && !misaligned) begin
               req_nxt   = 1'b1;
               we_nxt    = wmem_me;
               addr_nxt  = {ans_me[31:2], 2'b00};
               wdata_nxt = b_me;
               cnt_nxt   = 8'd0;
               state_nxt = BUSY;
            end else if (misaligned) begin
               align_nxt = 1'b1;
            end else begin
               wb_nxt.ans  = ans_me;
               wb_nxt.rw   = rw_me;
               wb_nxt.wreg = wreg_me;
            end
         end

         BUSY: begin
            if (bus.dmem_ack) begin
               wb_nxt.ans   = ans_me;
               wb_nxt.rw    = rw_me;
               wb_nxt.wreg  = wreg_me;
               wb_nxt.m2reg = m2reg_me & ~wmem_me;
               if (m2reg_me && !wmem_me) begin
                  wb_nxt.mo = bus.dmem_rdata;
               end
               req_nxt   = 1'b0;
               we_nxt    = 1'b0;
               state_nxt = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               // aborted instruction retires as a bubble
               req_nxt   = 1'b0;
               we_nxt    = 1'b0;
               berr_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt_q + 8'd1;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, bus-request and ME->WB registers; reset abandons any access.
   always_ff @(posedge clock or negedge reset_0) begin
      if (!reset_0) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         wb_q    <= '0;
         align_q <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         req_q   <= req_nxt;
         we_q    <= we_nxt;
         addr_q  <= addr_nxt;
         wdata_q <= wdata_nxt;
         wb_q    <= wb_nxt;
         align_q <= align_nxt;
         berr_q  <= berr_nxt;
      end
   end

   assign bus.dmem_req   = req_q;
   assign bus.dmem_we    = we_q;
   assign bus.dmem_addr  = addr_q;
   assign bus.dmem_wdata = wdata_q;

   assign ans_wb    = wb_q.ans;
   assign mo_wb     = wb_q.mo;
   assign rw_wb     = wb_q.rw;
   assign wreg_wb   = wb_q.wreg;
   assign m2reg_wb  = wb_q.m2reg;
   assign align_err = align_q;
   assign bus_err   = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by random instructions.
// Each instruction is scored at transaction level: from its fields and the
// chosen ack delay the bench works out how long it occupies ME, how many
// cycles stall is high, and what WB and the error pulses must show.
module tb_mem_stage;

   localparam int TO = 4;

   logic        clock;
   logic        reset_0;
   logic [31:0] ans_me;
   logic [31:0] b_me;
   logic [4:0]  rw_me;
   logic        wreg_me;
   logic        m2reg_me;
   logic        wmem_me;
   logic        stall_me;
   logic [31:0] ans_wb;
   logic [31:0] mo_wb;
   logic [4:0]  rw_wb;
   logic        wreg_wb;
   logic        m2reg_wb;
   logic        align_err;
   logic        bus_err;

   mem_stage_if bus ();

   mem_stage #(.TIMEOUT(TO)) dut (
      .clock     (clock),
      .reset_0   (reset_0),
      .ans_me    (ans_me),
      .b_me      (b_me),
      .rw_me     (rw_me),
      .wreg_me   (wreg_me),
      .m2reg_me  (m2reg_me),
      .wmem_me   (wmem_me),
      .stall_me  (stall_me),
      .bus       (bus),
      .ans_wb    (ans_wb),
      .mo_wb     (mo_wb),
      .rw_wb     (rw_wb),
      .wreg_wb   (wreg_wb),
      .m2reg_wb  (m2reg_wb),
      .align_err (align_err),
      .bus_err   (bus_err)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] mo_exp = 32'd0;   // memory data WB should currently hold
   int          stall_total = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_wb(input string tag, input logic [31:0] ans, input logic [4:0] rw,
                           input logic wreg, input logic m2reg, input logic aerr, input logic berr);
      check({tag, ".ans_wb"},    ans_wb,    ans);
      check({tag, ".mo_wb"},     mo_wb,     mo_exp);
      check({tag, ".rw_wb"},     32'(rw_wb), 32'(rw));
      check({tag, ".wreg_wb"},   wreg_wb,   wreg);
      check({tag, ".m2reg_wb"},  m2reg_wb,  m2reg);
      check({tag, ".align_err"}, align_err, aerr);
      check({tag, ".bus_err"},   bus_err,   berr);
   endtask

   // Apply one instruction at a negedge and score it. k is the cycle after
   // req rises in which ack is driven (k > TO means never); stray drives an
   // ack in the issuing IDLE cycle, which must be ignored. Returns at the
   // negedge after the instruction's last edge.
   task automatic run_instr(input string tag, input logic [31:0] ans, input logic [31:0] b,
                            input logic [4:0] rw, input logic wreg, input logic m2reg,
                            input logic wmem, input int k, input logic [31:0] rd,
                            input logic stray);
      logic is_mem;
      logic mis;
      int   last;
      is_mem = m2reg | wmem;
      mis    = is_mem && (ans[1:0] != 2'b00);
      if (!is_mem || mis) last = 0;
      else                last = (k <= TO) ? k : TO;

      ans_me   = ans;
      b_me     = b;
      rw_me    = rw;
      wreg_me  = wreg;
      m2reg_me = m2reg;
      wmem_me  = wmem;

      for (int c = 0; c <= last; c++) begin
         bus.dmem_ack   = (c == 0) ? stray : (c == k);
         bus.dmem_rdata = (c == k) ? rd : $urandom;
         #1;
         check({tag, ".stall"}, stall_me, is_mem && !mis && (c < last));
         if (stall_me) stall_total++;
         check({tag, ".req"}, bus.dmem_req, c >= 1);
         if (c >= 1) begin
            check({tag, ".align_hold"}, align_err, 1'b0);
            check({tag, ".berr_hold"},  bus_err,   1'b0);
         end
         if (c == 1) begin
            check({tag, ".we"},    bus.dmem_we,    wmem);
            check({tag, ".addr"},  bus.dmem_addr,  {ans[31:2], 2'b00});
            check({tag, ".wdata"}, bus.dmem_wdata, b);
         end
         @(posedge clock);
         @(negedge clock);
      end
      bus.dmem_ack = 1'b0;

      check({tag, ".req_done"}, bus.dmem_req, 1'b0);
      if (!is_mem) begin
         check_wb(tag, ans, rw, wreg, 1'b0, 1'b0, 1'b0);
      end else if (mis) begin
         check_wb(tag, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      end else if (k <= TO) begin
         if (m2reg && !wmem) mo_exp = rd;
         check_wb(tag, ans, rw, wreg, m2reg & ~wmem, 1'b0, 1'b0);
      end else begin
         check_wb(tag, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
   endtask

   initial begin
      reset_0        = 1'b0;
      ans_me         = 32'd0;
      b_me           = 32'd0;
      rw_me          = 5'd0;
      wreg_me        = 1'b0;
      m2reg_me       = 1'b0;
      wmem_me        = 1'b0;
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = 32'd0;

      // reset state
      repeat (2) @(negedge clock);
      #1;
      check("rst.req",   bus.dmem_req,   1'b0);
      check("rst.addr",  bus.dmem_addr,  32'd0);
      check("rst.stall", stall_me,       1'b0);
      check_wb("rst", 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      reset_0 = 1'b1;
      @(negedge clock);

      // reset in the middle of an outstanding load
      ans_me   = 32'h80;
      m2reg_me = 1'b1;
      wreg_me  = 1'b1;
      rw_me    = 5'd3;
      @(posedge clock);
      @(negedge clock);
      check("midrst.req_up", bus.dmem_req, 1'b1);
      #2 reset_0 = 1'b0;
      #1;
      check("midrst.req",   bus.dmem_req,   1'b0);
      check("midrst.we",    bus.dmem_we,    1'b0);
      check("midrst.addr",  bus.dmem_addr,  32'd0);
      check("midrst.wdata", bus.dmem_wdata, 32'd0);
      mo_exp = 32'd0;
      check_wb("midrst", 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      reset_0 = 1'b1;
      // ALU op right after release, with a late ack that must be ignored
      run_instr("alu", 32'h1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1, 32'd0, 1'b1);

      // directed scenarios
      run_instr("load3", 32'h40, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0, 3, 32'hDEADBEEF, 1'b0);
      run_instr("store1", 32'h10, 32'hCAFE0001, 5'd0, 1'b0, 1'b0, 1'b1, 1, 32'h0, 1'b0);
      run_instr("misal", 32'h42, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1, 32'h0, 1'b0);
      run_instr("tmo", 32'h100, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, TO + 5, 32'h0, 1'b0);
      run_instr("stray", 32'h77, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1, 32'h0, 1'b1);
      run_instr("both", 32'h20, 32'h5555AAAA, 5'd7, 1'b1, 1'b1, 1'b1, 2, 32'h12345678, 1'b0);
      check("both.mo_kept", mo_wb, 32'hDEADBEEF);

      // back-to-back load then store, each acked one cycle after req
      stall_total = 0;
      run_instr("b2b.ld", 32'h200, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, 1, 32'hA5A5_0F0F, 1'b0);
      check("b2b.gap_req", bus.dmem_req, 1'b0);
      run_instr("b2b.st", 32'h204, 32'h0BADF00D, 5'd0, 1'b0, 1'b0, 1'b1, 1, 32'h0, 1'b0);
      check("b2b.stalls", 32'(stall_total), 32'd2);

      // random instruction stream
      for (int i = 0; i < 400; i++) begin
         logic [31:0] ans;
         logic        m2r;
         logic        wm;
         int          kind;
         kind = $urandom_range(0, 3);
         m2r  = (kind == 1) || (kind == 3);
         wm   = (kind == 2) || (kind == 3);
         ans  = $urandom;
         if ($urandom_range(0, 4) != 0) ans[1:0] = 2'b00;
         run_instr("rnd", ans, $urandom, 5'($urandom), 1'($urandom), m2r, wm,
                   $urandom_range(1, TO + 2), $urandom, 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
